// File: rtl/control_puerta.sv
// control_puerta
//
// Single-door access sequencer for the warehouse gate. Arbitrates entry and
// exit requests onto the one physical door, drives the door actuator, waits
// for a confirmed passage from the S1/S2 direction detector, closes the door
// again and keeps the occupancy count against a capacity limit.
//
// Parameters:
//   CAP     maximum occupancy (entry refused when count == CAP), CAP <= 2^W-1
//   W       occupancy counter width
//   T_OPEN  cycles allowed for the limit switch to confirm open or closed
//   T_PASS  cycles allowed for a passage once the door is open
//
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   req_in     entry request (level, held until granted)
//   req_out    exit request (level)
//   pas_in     one-cycle pulse: entry passage completed
//   pas_out    one-cycle pulse: exit passage completed
//   door_open  limit switch, 1 = fully open, 0 = fully closed
//   door_cmd   1 = drive door open, 0 = drive closed
//   gnt_in     entry side granted (one-hot with gnt_out)
//   gnt_out    exit side granted
//   V          green light, pass now
//   R          red light, warehouse full or fault
//   count      current occupancy
//   full       count == CAP
//   empty      count == 0
//   err        fault latched (cleared only by rst)
//
// All outputs are decoded from registers only; there is no combinational
// path from any input to any output.

module control_puerta #(
  parameter int CAP    = 15,
  parameter int W      = 4,
  parameter int T_OPEN = 50,
  parameter int T_PASS = 200
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_in,
  input  logic         req_out,
  input  logic         pas_in,
  input  logic         pas_out,
  input  logic         door_open,
  output logic         door_cmd,
  output logic         gnt_in,
  output logic         gnt_out,
  output logic         V,
  output logic         R,
  output logic [W-1:0] count,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int T_MAX = (T_OPEN > T_PASS) ? T_OPEN : T_PASS;
  // The timer only ever has to hold values up to T_MAX-1.
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] OPEN_LAST = TW'(T_OPEN - 1);
  localparam logic [TW-1:0] PASS_LAST = TW'(T_PASS - 1);
  localparam logic [W-1:0]  CAP_W     = W'(CAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABRIR,
    S_PASO,
    S_CERRAR,
    S_FALLO
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  count_q, count_d;
  logic          gnt_in_q, gnt_in_d;
  logic          gnt_out_q, gnt_out_d;
  // 1 = the exit side was served last, so an entry wins the next tie.
  logic          prio_out_q, prio_out_d;

  logic          elig_in;
  logic          elig_out;

  // Entry is only eligible with room left and exit only with someone inside,
  // which is what keeps the counter from ever wrapping.
  assign elig_in  = req_in  & ~full;
  assign elig_out = req_out & ~empty;

  // Next-state, counter, grant and priority logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    count_d    = count_q;
    gnt_in_d   = gnt_in_q;
    gnt_out_d  = gnt_out_q;
    prio_out_d = prio_out_q;

    unique case (state_q)
      S_IDLE: begin
        // On a tie the side opposite to the last one served wins.
        if (elig_in && (!elig_out || prio_out_q)) begin
          gnt_in_d = 1'b1;
          state_d  = S_ABRIR;
        end else if (elig_out) begin
          gnt_out_d = 1'b1;
          state_d   = S_ABRIR;
        end
      end

      S_ABRIR: begin
        if (door_open) begin
          state_d = S_PASO;
        end else if (timer_q == OPEN_LAST) begin
          state_d = S_FALLO;
        end
      end

      S_PASO: begin
        // A pulse in the wrong direction, or both at once, means someone is
        // moving against the granted flow: treat it as a fault.
        if (pas_in && pas_out) begin
          state_d = S_FALLO;
        end else if (pas_in) begin
          if (gnt_in_q) begin
            count_d = count_q + W'(1);
            state_d = S_CERRAR;
          end else begin
            state_d = S_FALLO;
          end
        end else if (pas_out) begin
          if (gnt_out_q) begin
            count_d = count_q - W'(1);
            state_d = S_CERRAR;
          end else begin
            state_d = S_FALLO;
          end
        end else if (timer_q == PASS_LAST) begin
          state_d = S_CERRAR;
        end
      end

      S_CERRAR: begin
        if (!door_open) begin
          state_d    = S_IDLE;
          prio_out_d = gnt_out_q;
          gnt_in_d   = 1'b0;
          gnt_out_d  = 1'b0;
        end else if (timer_q == OPEN_LAST) begin
          state_d = S_FALLO;
        end
      end

      S_FALLO: begin
        state_d = S_FALLO;
      end

      default: begin
        state_d = S_FALLO;
      end
    endcase

    // Grants are dropped the moment a fault is entered.
    if (state_d == S_FALLO) begin
      gnt_in_d  = 1'b0;
      gnt_out_d = 1'b0;
    end

    // The timer restarts on every state change and only runs in the states
    // that can time out.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (state_q == S_ABRIR || state_q == S_PASO || state_q == S_CERRAR) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      count_q    <= '0;
      gnt_in_q   <= 1'b0;
      gnt_out_q  <= 1'b0;
      prio_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      gnt_in_q   <= gnt_in_d;
      gnt_out_q  <= gnt_out_d;
      prio_out_q <= prio_out_d;
    end
  end

  assign full     = (count_q == CAP_W);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign gnt_in   = gnt_in_q;
  assign gnt_out  = gnt_out_q;
  assign door_cmd = (state_q == S_ABRIR) || (state_q == S_PASO);
  assign V        = (state_q == S_PASO);
  assign err      = (state_q == S_FALLO);
  assign R        = err | ((state_q == S_IDLE) & full);

endmodule

// File: tb/tb_control_puerta.sv
// tb_control_puerta
//
// Self-checking bench for control_puerta. A behavioural model tracks the
// door phase by the cycle number at which each phase was entered, and a
// compare process checks every DUT output against it on each falling edge.
// Directed sequences add hand-computed literal checks that pin the model.

module tb_control_puerta;

  localparam int CAP    = 7;
  localparam int W      = 4;
  localparam int T_OPEN = 6;
  localparam int T_PASS = 10;

  localparam int P_WAIT  = 0;
  localparam int P_OPEN  = 1;
  localparam int P_PASS  = 2;
  localparam int P_CLOSE = 3;
  localparam int P_FAULT = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         req_in    = 1'b0;
  logic         req_out   = 1'b0;
  logic         pas_in    = 1'b0;
  logic         pas_out   = 1'b0;
  logic         door_open = 1'b0;
  logic         door_cmd;
  logic         gnt_in;
  logic         gnt_out;
  logic         V;
  logic         R;
  logic [W-1:0] count;
  logic         full;
  logic         empty;
  logic         err;

  int nVectors     = 0;
  int nMiscompares = 0;

  control_puerta #(
    .CAP(CAP), .W(W), .T_OPEN(T_OPEN), .T_PASS(T_PASS)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out),
    .pas_in(pas_in), .pas_out(pas_out), .door_open(door_open),
    .door_cmd(door_cmd), .gnt_in(gnt_in), .gnt_out(gnt_out),
    .V(V), .R(R), .count(count), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  // Model state: current phase, occupancy, grant, who was served last, and
  // the edge number at which the current phase began.
  int mPhase   = P_WAIT;
  int mCount   = 0;
  bit mGin     = 1'b0;
  bit mGout    = 1'b0;
  bit mLastOut = 1'b1;
  int mCyc     = 0;
  int mEnter   = 0;
  int mElapsed = 0;
  int mNext    = P_WAIT;

  // Behavioural model: timeouts are expressed as "this many edges after the
  // phase was entered", straight from the timing rules of the door.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase   = P_WAIT;
      mCount   = 0;
      mGin     = 1'b0;
      mGout    = 1'b0;
      mLastOut = 1'b1;
      mCyc     = 0;
      mEnter   = 0;
    end else begin
      mCyc     = mCyc + 1;
      mElapsed = mCyc - mEnter;
      mNext    = mPhase;
      case (mPhase)
        P_WAIT: begin
          if (req_in && mCount < CAP && (!(req_out && mCount > 0) || mLastOut)) begin
            mGin  = 1'b1;
            mNext = P_OPEN;
          end else if (req_out && mCount > 0) begin
            mGout = 1'b1;
            mNext = P_OPEN;
          end
        end
        P_OPEN: begin
          if (door_open) mNext = P_PASS;
          else if (mElapsed >= T_OPEN) mNext = P_FAULT;
        end
        P_PASS: begin
          if (pas_in && pas_out) begin
            mNext = P_FAULT;
          end else if ((pas_in && mGin) || (pas_out && mGout)) begin
            mCount = mGin ? mCount + 1 : mCount - 1;
            mNext  = P_CLOSE;
          end else if (pas_in || pas_out) begin
            mNext = P_FAULT;
          end else if (mElapsed >= T_PASS) begin
            mNext = P_CLOSE;
          end
        end
        P_CLOSE: begin
          if (!door_open) begin
            mLastOut = mGout;
            mGin     = 1'b0;
            mGout    = 1'b0;
            mNext    = P_WAIT;
          end else if (mElapsed >= T_OPEN) begin
            mNext = P_FAULT;
          end
        end
        default: mNext = P_FAULT;
      endcase
      if (mNext == P_FAULT) begin
        mGin  = 1'b0;
        mGout = 1'b0;
      end
      if (mNext != mPhase) mEnter = mCyc;
      mPhase = mNext;
    end
  end

  // One comparison, counted, with a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare process: every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model door_cmd", door_cmd, (mPhase == P_OPEN || mPhase == P_PASS));
      checkOutput("model gnt_in", gnt_in, mGin);
      checkOutput("model gnt_out", gnt_out, mGout);
      checkOutput("model V", V, (mPhase == P_PASS));
      checkOutput("model R", R, (mPhase == P_FAULT || (mPhase == P_WAIT && mCount == CAP)));
      checkOutput("model count", count, mCount);
      checkOutput("model full", full, (mCount == CAP));
      checkOutput("model empty", empty, (mCount == 0));
      checkOutput("model err", err, (mPhase == P_FAULT));
    end
  end

  // Drive all inputs and let the given number of rising edges go by; inputs
  // change 1 time unit after an edge so they are stable at the next one.
  task automatic applyStimulus(input bit rin, input bit rout, input bit pin,
                               input bit pout, input bit dopen, input int cycles);
    req_in    = rin;
    req_out   = rout;
    pas_in    = pin;
    pas_out   = pout;
    door_open = dopen;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    checkOutput("reset count", count, 0);
    checkOutput("reset err", err, 0);
  endtask

  // A complete normal door cycle: grant, open, passage, close.
  task automatic trip(input bit rin, input bit rout, input bit expOut, input int expCount);
    applyStimulus(rin, rout, 0, 0, 0, 1);
    checkOutput("trip gnt_in", gnt_in, !expOut);
    checkOutput("trip gnt_out", gnt_out, expOut);
    applyStimulus(rin, rout, 0, 0, 1, 1);
    applyStimulus(rin, rout, !expOut, expOut, 1, 1);
    checkOutput("trip count", count, expCount);
    applyStimulus(rin, rout, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset values.
    applyStimulus(0, 0, 0, 0, 0, 2);
    checkOutput("reset door_cmd", door_cmd, 0);
    checkOutput("reset empty", empty, 1);
    checkOutput("reset R", R, 0);
    rst = 1'b0;

    // Basic entry with the door opening three cycles after the grant.
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("entry gnt_in", gnt_in, 1);
    checkOutput("entry door_cmd", door_cmd, 1);
    applyStimulus(0, 0, 0, 0, 0, 3);
    checkOutput("entry waiting V", V, 0);
    checkOutput("entry waiting door_cmd", door_cmd, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("entry V", V, 1);
    applyStimulus(0, 0, 1, 0, 1, 1);
    checkOutput("entry count", count, 1);
    checkOutput("entry closing door_cmd", door_cmd, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("entry done gnt_in", gnt_in, 0);

    // Fill to 6, one exit so the exit side was served last, then both
    // requests held: entry must win, then exit.
    for (int c = 2; c <= 6; c++) trip(1, 0, 0, c);
    trip(0, 1, 1, 5);
    trip(1, 1, 0, 6);
    trip(1, 1, 1, 5);

    // Fill to capacity; further entry requests are refused.
    trip(1, 0, 0, 6);
    trip(1, 0, 0, 7);
    applyStimulus(1, 0, 0, 0, 0, 2);
    checkOutput("full flag", full, 1);
    checkOutput("full R", R, 1);
    checkOutput("full no grant", gnt_in, 0);
    checkOutput("full door_cmd", door_cmd, 0);
    trip(1, 1, 1, 6);
    checkOutput("after exit R", R, 0);

    // Drain to empty; exit requests are then refused.
    for (int c = 5; c >= 0; c--) trip(0, 1, 1, c);
    applyStimulus(0, 1, 0, 0, 0, 3);
    checkOutput("empty no grant", gnt_out, 0);
    checkOutput("empty flag", empty, 1);
    checkOutput("empty door_cmd", door_cmd, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);

    // Door never opens: fault exactly T_OPEN edges after the grant.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, T_OPEN - 1);
    checkOutput("open timeout pending err", err, 0);
    checkOutput("open timeout pending door_cmd", door_cmd, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("open timeout err", err, 1);
    checkOutput("open timeout R", R, 1);
    checkOutput("open timeout door_cmd", door_cmd, 0);
    checkOutput("open timeout gnt_in", gnt_in, 0);
    applyStimulus(1, 1, 0, 0, 1, 5);
    checkOutput("fault sticky err", err, 1);
    checkOutput("fault sticky gnt_out", gnt_out, 0);
    doReset();

    // Counter-flow pulse during an entry: fault, count untouched.
    trip(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 1);
    checkOutput("counterflow err", err, 1);
    checkOutput("counterflow count", count, 1);
    doReset();

    // Nobody passes: door closes T_PASS edges after opening, no fault.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, T_PASS - 1);
    checkOutput("pass timeout pending V", V, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("pass timeout V", V, 0);
    checkOutput("pass timeout door_cmd", door_cmd, 0);
    checkOutput("pass timeout err", err, 0);
    checkOutput("pass timeout count", count, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("pass timeout closed gnt_in", gnt_in, 0);

    // Both pulses in the same cycle: fault.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 1, 1, 1);
    checkOutput("double pulse err", err, 1);
    checkOutput("double pulse count", count, 0);
    doReset();

    // Door stuck open while closing: fault after T_OPEN edges.
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 1, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 1, T_OPEN - 1);
    checkOutput("close timeout pending err", err, 0);
    applyStimulus(0, 0, 0, 0, 1, 1);
    checkOutput("close timeout err", err, 1);
    checkOutput("close timeout count", count, 1);
    doReset();

    // Reset in the middle of a passage takes effect immediately.
    trip(1, 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 1);
    rst = 1'b1;
    #1;
    checkOutput("midreset door_cmd", door_cmd, 0);
    checkOutput("midreset count", count, 0);
    checkOutput("midreset V", V, 0);
    applyStimulus(0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    nMiscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/control_puerta.md
# control_puerta

Single-door access sequencer for the warehouse gate: arbitrates entry and exit requests onto the one physical door, drives the door actuator, and waits for a confirmed passage from the upstream S1/S2 direction detector. It then closes the door and maintains the occupancy count against a capacity limit. It sits between the request buttons/direction detector and the door motor plus the V/R signal lights.

## Interface
- CAP, 15: maximum occupancy; entry refused when count equals CAP.
- W, 4: count width; CAP must be at most 2^W-1.
- T_OPEN, 50: cycles allowed for the door limit switch to confirm open or closed.
- T_PASS, 200: cycles allowed for a passage after the door is open.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  1  entry request, level, held by requester until granted.
- req_out  in  1  exit request, level.
- pas_in  in  1  one-cycle pulse from direction detector: entry passage completed.
- pas_out  in  1  one-cycle pulse: exit passage completed.
- door_open  in  1  limit switch, 1 = door fully open, 0 = fully closed.
- door_cmd  out  1  1 = drive door open, 0 = drive closed.
- gnt_in  out  1  entry side granted (one-hot with gnt_out).
- gnt_out  out  1  exit side granted.
- V  out  1  green light: pass now.
- R  out  1  red light: warehouse full or fault.
- count  out  W  current occupancy.
- full  out  1  count == CAP.
- empty  out  1  count == 0.
- err  out  1  fault latched.

## Operation
- States: IDLE, ABRIR, PASO, CERRAR, FALLO. A timer (width sufficient for max(T_OPEN,T_PASS)) clears on every state change.
- IDLE: eligible_in = req_in & ~full; eligible_out = req_out & ~empty. One eligible side: grant it. Both eligible: grant the side opposite to prio. Neither: stay. On grant, load gnt_in/gnt_out and go to ABRIR.
- ABRIR: door_cmd=1. door_open=1 -> PASO. Timer reaching T_OPEN-1 with door_open=0 -> FALLO.
- PASO: door_cmd=1, V=1. Pulse matching the grant: count +1 (in) or -1 (out), then CERRAR. Pulse of the opposite direction (counter-flow): -> FALLO, count unchanged. Timer reaching T_PASS-1 -> CERRAR, count unchanged. Both pulses in the same cycle: FALLO.
- CERRAR: door_cmd=0. door_open=0 -> IDLE, grants cleared, prio set to the side just served. Timer reaching T_OPEN-1 -> FALLO.
- FALLO: door_cmd=0, grants 0, err=1, R=1. Only rst exits this state.
- R = FALLO | (IDLE & full). full and empty decode from the count register.
- pas_in/pas_out outside PASO are ignored. Count never wraps, because eligibility excludes entry when full and exit when empty.

## Timing
- Reset values: state IDLE, count 0, prio = out (entry wins the first tie), timer 0. door_cmd, gnt_in, gnt_out, V, R, err, full = 0; empty = 1.
- All outputs are Moore-decoded from registers; no combinational path from inputs to outputs.
- Request sampled in IDLE at edge k: grant and door_cmd high from k+1.
- door_open sampled at edge k in ABRIR: V high from k+1.
- Pass pulse at edge k in PASO: count updated and door_cmd low from k+1.
- door_open=0 at edge k in CERRAR: grants low from k+1. A new request can be sampled at k+1, so the earliest next grant is at k+2.
- Timeout: ABRIR entered at edge e with door_open held 0: FALLO visible from e+T_OPEN.
- A request dropped after grant does not abort the sequence.
- rst asserted mid-sequence: immediate return to reset values, door_cmd low and count lost.

## Test plan
- Reset, req_in=1, door_open rises 3 cycles after grant, pas_in pulse -> gnt_in, door_cmd high one cycle after request; V high one cycle after door_open; count 0->1 and door_cmd low one cycle after pulse; door_open low -> IDLE.
- req_in and req_out both held with count=5, door completes normally -> first grant is gnt_in (count 6); the second cycle grants gnt_out (count 5), confirming alternation.
- CAP=2: complete two entries, then req_in=1 -> full=1, R=1, no grant; req_out=1 -> grant out, count 1, R=0.
- count=0, req_out=1 -> no grant, empty=1, door_cmd stays 0.
- Granted entry, door_open never rises -> FALLO after T_OPEN cycles, err=1, R=1, door_cmd=0. Holds through further requests until rst.
- Granted entry in PASO, pas_out pulse -> FALLO, count unchanged. Repeat with no pulse -> CERRAR after T_PASS cycles, count unchanged, err=0.
